// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: word-indexed data memory access with sub-word
// read-modify-write stores and registered, extended load responses.
module load_store_unit #(
  parameter int unsigned ADDR_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        fault
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RD_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE,
    S_MERGE
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   merge_q, merge_d;
  logic [XLEN-1:0]   idx_q, idx_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic [RD_W-1:0]   resp_rd_q, resp_rd_d;
  logic              fault_q, fault_d;

  logic [XLEN-1:0]   word_idx;
  logic              in_range;
  logic              f3_ok;
  logic              align_ok;
  logic              legal;
  logic [4:0]        byte_sh;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   merged;
  logic              stall_raw;
  logic              mem_we_raw;

  // Request decode: word index, legality, lane extraction and store merge.
  always_comb begin
    word_idx = {2'b00, req_addr[31:2]};
    in_range = (word_idx < XLEN'(ADDR_WORDS));
    f3_ok    = 1'b0;
    align_ok = 1'b1;
    case (req_funct3)
      F3_B:  f3_ok = 1'b1;
      F3_H:  begin f3_ok = 1'b1;     align_ok = ~req_addr[0]; end
      F3_W:  begin f3_ok = 1'b1;     align_ok = (req_addr[1:0] == 2'b00); end
      F3_BU: f3_ok = ~req_we;
      F3_HU: begin f3_ok = ~req_we;  align_ok = ~req_addr[0]; end
      default: f3_ok = 1'b0;
    endcase
    legal = f3_ok & align_ok & in_range;

    byte_sh = {req_addr[1:0], 3'b000};
    shifted = mem_rdata >> byte_sh;
    case (req_funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = mem_rdata;
    endcase

    merged = mem_rdata;
    if (req_funct3 == F3_B) begin
      merged[byte_sh +: 8] = req_wdata[7:0];
    end else begin
      merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end
  end

  // Next-state and memory-side outputs.
  always_comb begin
    state_d      = state_q;
    merge_d      = merge_q;
    idx_d        = idx_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    fault_d      = 1'b0;
    stall_raw    = 1'b0;
    mem_we_raw   = 1'b0;
    mem_addr     = word_idx;
    mem_wdata    = req_wdata;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!legal) begin
            fault_d = 1'b1;
          end else if (!req_we) begin
            resp_valid_d = 1'b1;
            resp_data_d  = load_data;
            resp_rd_d    = req_rd;
          end else if (req_funct3 == F3_W) begin
            mem_we_raw = 1'b1;
          end else begin
            stall_raw = 1'b1;
            merge_d   = merged;
            idx_d     = word_idx;
            state_d   = S_MERGE;
          end
        end
      end
      S_MERGE: begin
        mem_addr   = idx_q;
        mem_wdata  = merge_q;
        mem_we_raw = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset suppresses any write, including an in-flight merge.
    mem_we = mem_we_raw & ~rst;
    stall  = stall_raw & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      merge_q      <= '0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      idx_q        <= idx_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      fault_q      <= fault_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        stall;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        fault;

  logic [31:0] mem [1024];

  int n_assert;
  int n_fail;

  load_store_unit #(.ADDR_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .stall(stall), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'd1024) mem[mem_addr[9:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply a request at the falling edge and let combinational outputs settle.
  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    req_valid = v; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] rd, input logic [31:0] exp);
    drive(1'b1, 1'b0, f3, a, 32'h0, rd);
    chk({tag, "_we"}, 32'(mem_we), 32'h0);
    tick();
    chk({tag, "_valid"}, 32'(resp_valid), 32'h1);
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_rd"}, 32'(resp_rd), 32'(rd));
    chk({tag, "_fault"}, 32'(fault), 32'h0);
  endtask

  task automatic illegal_chk(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] a);
    drive(1'b1, we, f3, a, 32'h5555_5555, 5'd9);
    chk({tag, "_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_stall"}, 32'(stall), 32'h0);
    tick();
    chk({tag, "_fault"}, 32'(fault), 32'h1);
    chk({tag, "_valid"}, 32'(resp_valid), 32'h0);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    tick();
    chk({tag, "_fault_pulse"}, 32'(fault), 32'h0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    tick();
    tick();
    chk("rst_valid", 32'(resp_valid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_data", resp_data, 32'h0);
    chk("rst_rd", 32'(resp_rd), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // SW then LW on word 4
    drive(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd1);
    chk("sw_addr", mem_addr, 32'd4);
    chk("sw_we", 32'(mem_we), 32'h1);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_stall", 32'(stall), 32'h0);
    tick();
    chk("sw_mem", mem[4], 32'hDEAD_BEEF);
    chk("sw_valid", 32'(resp_valid), 32'h0);
    load_chk("lw", 3'b010, 32'h10, 5'd7, 32'hDEAD_BEEF);

    // SB 0x11 read-modify-write
    drive(1'b1, 1'b1, 3'b000, 32'h11, 32'h0000_00A5, 5'd0);
    chk("sb_c0_stall", 32'(stall), 32'h1);
    chk("sb_c0_we", 32'(mem_we), 32'h0);
    tick();
    #1;
    chk("sb_c1_we", 32'(mem_we), 32'h1);
    chk("sb_c1_wdata", mem_wdata, 32'hDEAD_A5EF);
    chk("sb_c1_addr", mem_addr, 32'd4);
    chk("sb_c1_stall", 32'(stall), 32'h0);
    tick();
    chk("sb_mem", mem[4], 32'hDEAD_A5EF);

    // SH 0x12
    drive(1'b1, 1'b1, 3'b001, 32'h12, 32'h0000_1234, 5'd0);
    chk("sh_c0_stall", 32'(stall), 32'h1);
    tick();
    #1;
    chk("sh_c1_wdata", mem_wdata, 32'h1234_A5EF);
    chk("sh_c1_we", 32'(mem_we), 32'h1);
    tick();
    chk("sh_mem", mem[4], 32'h1234_A5EF);

    // Sub-word loads from 0xDEADBEEF
    drive(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd0);
    tick();
    load_chk("lb13",  3'b000, 32'h13, 5'd2,  32'hFFFF_FFDE);
    load_chk("lbu13", 3'b100, 32'h13, 5'd3,  32'h0000_00DE);
    load_chk("lh12",  3'b001, 32'h12, 5'd4,  32'hFFFF_DEAD);
    load_chk("lhu12", 3'b101, 32'h12, 5'd5,  32'h0000_DEAD);
    load_chk("lb10",  3'b000, 32'h10, 5'd31, 32'hFFFF_FFEF);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    tick();
    chk("resp_pulse", 32'(resp_valid), 32'h0);

    // Illegal requests
    illegal_chk("ill_lw12",  1'b0, 3'b010, 32'h12);
    illegal_chk("ill_sh11",  1'b1, 3'b001, 32'h11);
    illegal_chk("ill_sw1k",  1'b1, 3'b010, 32'h1000);
    illegal_chk("ill_f3011", 1'b0, 3'b011, 32'h10);
    illegal_chk("ill_sbu",   1'b1, 3'b100, 32'h10);
    chk("ill_mem4", mem[4], 32'hDEAD_BEEF);

    // SH with reset during MERGE
    drive(1'b1, 1'b1, 3'b010, 32'h20, 32'h1122_3344, 5'd0);
    tick();
    drive(1'b1, 1'b1, 3'b001, 32'h20, 32'h0000_AAAA, 5'd0);
    chk("rstm_c0_stall", 32'(stall), 32'h1);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstm_we", 32'(mem_we), 32'h0);
    chk("rstm_stall", 32'(stall), 32'h0);
    tick();
    chk("rstm_mem", mem[8], 32'h1122_3344);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rstm_post_stall", 32'(stall), 32'h0);
    chk("rstm_post_we", 32'(mem_we), 32'h0);
    tick();
    load_chk("rstm_lw", 3'b010, 32'h20, 5'd6, 32'h1122_3344);

    // SH then immediate LW on the same word
    drive(1'b1, 1'b1, 3'b001, 32'h14, 32'h0000_BEEF, 5'd0);
    tick();
    tick();
    load_chk("b2b_lw", 3'b010, 32'h14, 5'd8, 32'h0000_BEEF);

    // Idle cycles
    drive(1'b0, 1'b1, 3'b010, 32'h14, 32'hFFFF_FFFF, 5'd0);
    for (int i = 0; i < 3; i++) begin
      chk("idle_we", 32'(mem_we), 32'h0);
      tick();
      chk("idle_valid", 32'(resp_valid), 32'h0);
      chk("idle_fault", 32'(fault), 32'h0);
    end
    chk("idle_mem5", mem[5], 32'h0000_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage load/store unit of the RISC-V pipeline. It sits between the EX/MEM pipeline register and the word-addressed data memory, which has a combinational read and a full-word synchronous write. It converts byte, halfword and word accesses into word-indexed memory operations, implementing sub-word stores as a two-cycle read-modify-write. It returns registered, sign- or zero-extended load data to the MEM/WB stage and stalls the pipeline while a sub-word store is in progress.

## Interface
- ADDR_WORDS, 1024: number of 32-bit words in data memory. A word index at or above this value is out of range.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  access request present this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; relevant bits are the low lane
- req_rd  in  5  destination register, passed through for loads
- stall  out  1  pipeline must hold the request and the EX/MEM register
- mem_addr  out  32  word index, {2'b00, addr[31:2]}
- mem_we  out  1  memory write enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr
- resp_valid  out  1  registered load result valid (one-cycle pulse)
- resp_data  out  32  registered, extended load data
- resp_rd  out  5  registered req_rd
- fault  out  1  registered one-cycle pulse for a misaligned, illegal or out-of-range request

## Operation
**States**
- IDLE: accepts requests.
- MERGE: write cycle of a sub-word store.

**Legality**
- Loads: funct3 must be in {000, 001, 010, 100, 101}.
- Stores: funct3 must be in {000, 001, 010}.
- H/HU require addr[0]=0.
- W requires addr[1:0]=0.
- The word index must be below ADDR_WORDS.
- An illegal request:
  - never writes memory and never stalls;
  - sets resp_valid=0;
  - asserts fault=1 on the next cycle.

**IDLE with a legal request**
- Load:
  - mem_addr = word index; mem_we=0.
  - At the edge, lane (byte addr[1:0], halfword addr[1]) is registered into resp_data.
  - Extension: sign-extended for B/H, zero-extended for BU/HU, unchanged for W.
  - resp_valid=1 and resp_rd=req_rd are registered.
- SW: mem_we=1, mem_wdata=req_wdata, no stall, resp_valid=0.
- SB/SH (read cycle):
  - mem_we=0, stall=1.
  - merge_reg is loaded with mem_rdata, with the target lane replaced by req_wdata[7:0] or [15:0].
  - The word index is registered.
  - Next state is MERGE.

**MERGE**
- mem_addr = registered index; mem_we=1; mem_wdata=merge_reg.
- stall=0.
- Request inputs are ignored (pipeline still holds the same store).
- Next state is IDLE.

**Other rules**
- req_valid=0 in IDLE: mem_we=0, no response, no fault.
- mem_we is forced to 0 in any cycle where rst=1.
- stall is combinational and is 0 while rst=1.

## Timing
- Reset values:
  - state IDLE.
  - merge_reg, the registered index, resp_data and resp_rd are 0.
  - resp_valid=0, fault=0.
- Load latency: resp_valid/resp_data valid one cycle after the accept cycle.
- SW: writes at the edge ending the accept cycle; occupancy 1 cycle.
- SB/SH: occupancy 2 cycles; stall=1 in the first, memory written at the edge ending the second.
- Back-to-back ordering: a load to the same word accepted in the cycle after MERGE reads the updated word; no forwarding is needed.
- rst during MERGE: no write occurs, memory is unchanged, and the unit is IDLE with stall=0 next cycle.
- fault and resp_valid are never 1 in the same cycle.

## Test plan
1. Reset, then SW at 0x10 with data 0xDEADBEEF -> mem_addr=4, mem_we=1, mem_wdata=0xDEADBEEF, stall=0. Then LW 0x10 -> next cycle resp_valid=1, resp_data=0xDEADBEEF, resp_rd echoes the request.
2. SB at 0x11 with req_wdata=0x000000A5 on word 0xDEADBEEF -> cycle 0: stall=1, mem_we=0. Cycle 1: mem_we=1, mem_wdata=0xDEADA5EF, stall=0. Then SH at 0x12 with 0x1234 -> write of 0x1234A5EF.
3. Word 0xDEADBEEF with loads:
   - LB 0x13 -> 0xFFFFFFDE
   - LBU 0x13 -> 0x000000DE
   - LH 0x12 -> 0xFFFFDEAD
   - LHU 0x12 -> 0x0000DEAD
   - LB 0x10 -> 0xFFFFFFEF
4. Illegal requests, each -> fault=1 for one cycle, resp_valid=0, mem_we never asserted:
   - LW 0x12
   - SH 0x11
   - SW 0x1000 (word 1024)
   - load funct3=011
5. SH at 0x20 with rst raised in the MERGE cycle -> mem_we=0 that cycle, word at index 8 unchanged, stall=0 and state IDLE afterwards.
6. SH at 0x14 (0xBEEF onto 0x00000000), then LW 0x14 immediately after MERGE -> resp_data=0x0000BEEF. req_valid=0 idle cycles produce no resp_valid and no fault.
